// File: rtl/wavelet_sum_serializer.sv
// Captures a packed snapshot of per-filter sums and streams it out word by word over valid/ready.
// Optional build macro SERIALIZER_HEADER_EN prepends a constant 0xA5-pattern sync word to every frame.
module wavelet_sum_serializer #(
    parameter int TOTAL_FILTERS = 3,
    parameter int SUM_BITS      = 32,
    parameter int OUT_BITS      = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [TOTAL_FILTERS*SUM_BITS-1:0] i_sum,
    input  logic                              i_sum_valid,
    output logic [OUT_BITS-1:0]               o_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_first,
    output logic                              o_last,
    output logic                              o_overrun
);

    localparam int WORDS_PER_SUM = SUM_BITS / OUT_BITS;
    localparam int DATA_WORDS    = TOTAL_FILTERS * WORDS_PER_SUM;
    localparam int SHADOW_W      = TOTAL_FILTERS * SUM_BITS;
`ifdef SERIALIZER_HEADER_EN
    localparam int HDR_WORDS     = 1;
`else
    localparam int HDR_WORDS     = 0;
`endif
    localparam int FRAME_LEN     = DATA_WORDS + HDR_WORDS;
    localparam int CNT_W         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

`ifdef SERIALIZER_HEADER_EN
    // Sync word: the 0xA5 byte pattern repeated (or truncated) to the output width, LSB aligned.
    function automatic logic [OUT_BITS-1:0] sync_word();
        logic [7:0]          pat;
        logic [OUT_BITS-1:0] w;
        pat = 8'hA5;
        w   = {OUT_BITS{1'b0}};
        for (int i = 0; i < OUT_BITS; i++) begin
            w[i] = pat[i % 8];
        end
        return w;
    endfunction
`endif

    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [SHADOW_W-1:0] shadow_r;
    logic [SHADOW_W-1:0] shadow_nxt_s;
    logic                overrun_r;
    logic                overrun_nxt_s;
    logic                handshake_s;
    logic [OUT_BITS-1:0] data_r;
    logic                valid_r;
    logic                first_r;
    logic                last_r;
    logic [OUT_BITS-1:0] words_s [FRAME_LEN];

    assign handshake_s = (state_r == ST_SEND) && i_ready;

    // Frame sequencing: capture, count handshakes, chain a new snapshot on the final handshake.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shadow_nxt_s  = shadow_r;
        overrun_nxt_s = overrun_r;
        case (state_r)
            ST_IDLE: begin
                if (i_sum_valid) begin
                    shadow_nxt_s = i_sum;
                    cnt_nxt_s    = CNT_ZERO;
                    state_nxt_s  = ST_SEND;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (handshake_s && (cnt_r == CNT_LAST)) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (i_sum_valid) begin
                        // Strobe on the final handshake is a seamless hand-off, not an overrun.
                        shadow_nxt_s = i_sum;
                        state_nxt_s  = ST_SEND;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end else begin
                    if (handshake_s) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    if (i_sum_valid) begin
                        overrun_nxt_s = 1'b1;
                    end else begin
                        overrun_nxt_s = overrun_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Word table of the next snapshot: optional header, then filter 0 upward, MS word first.
    always_comb begin
        for (int w = 0; w < FRAME_LEN; w++) begin
            words_s[w] = {OUT_BITS{1'b0}};
        end
`ifdef SERIALIZER_HEADER_EN
        words_s[0] = sync_word();
`endif
        for (int f = 0; f < TOTAL_FILTERS; f++) begin
            for (int j = 0; j < WORDS_PER_SUM; j++) begin
                words_s[HDR_WORDS + f*WORDS_PER_SUM + j] =
                    shadow_nxt_s[SUM_BITS*f + SUM_BITS - OUT_BITS*(j+1) +: OUT_BITS];
            end
        end
    end

    // State, shadow and registered outputs; outputs are computed from next-state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            shadow_r  <= {SHADOW_W{1'b0}};
            overrun_r <= 1'b0;
            data_r    <= {OUT_BITS{1'b0}};
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shadow_r  <= shadow_nxt_s;
            overrun_r <= overrun_nxt_s;
            valid_r   <= (state_nxt_s == ST_SEND);
            first_r   <= (state_nxt_s == ST_SEND) && (cnt_nxt_s == CNT_ZERO);
            last_r    <= (state_nxt_s == ST_SEND) && (cnt_nxt_s == CNT_LAST);
            if (state_nxt_s == ST_SEND) begin
                data_r <= words_s[cnt_nxt_s];
            end else begin
                data_r <= {OUT_BITS{1'b0}};
            end
        end
    end

    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_first   = first_r;
    assign o_last    = last_r;
    assign o_overrun = overrun_r;

endmodule

// File: tb/tb_wavelet_sum_serializer.sv
// Directed bench for wavelet_sum_serializer: expected words queued at each strobe, checked on handshake.
// Honours SERIALIZER_HEADER_EN when the same macro is defined for the design.
module tb_wavelet_sum_serializer;

`ifdef SERIALIZER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FL = 12 + HDR;

    logic        clk;
    logic        rst_n;
    logic [95:0] i_sum;
    logic        i_sum_valid;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_first;
    logic        o_last;
    logic        o_overrun;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    wavelet_sum_serializer dut (
        .clk(clk), .rst_n(rst_n), .i_sum(i_sum), .i_sum_valid(i_sum_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_first(o_first), .o_last(o_last), .o_overrun(o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected words of one frame built from the packed sums.
    task automatic push_frame(input logic [95:0] s);
        exp_t e;
        if (HDR == 1) begin
            e.d = 8'hA5; e.f = 1'b1; e.l = 1'b0;
            q.push_back(e);
        end
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 4; j++) begin
                e.d = s[32*f + 24 - 8*j +: 8];
                e.f = (HDR == 0) && (f == 0) && (j == 0);
                e.l = (f == 2) && (j == 3);
                q.push_back(e);
            end
        end
    endtask

    // Caller sits at posedge+1; strobe is high for exactly one cycle.
    task automatic strobe(input logic [95:0] s);
        i_sum = s;
        i_sum_valid = 1'b1;
        @(posedge clk); #1;
        i_sum_valid = 1'b0;
        i_sum = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain(input string tag, input bit toggle, input bit contig, input int exp_cycles);
        int cycles = 0;
        while (q.size() != 0 && cycles < 80) begin
            @(posedge clk); #1;
            cycles++;
            if (toggle) i_ready = ~i_ready;
            if (contig && q.size() != 0) chk({tag, "_no_gap"}, 32'(o_valid), 32'd1);
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        if (exp_cycles > 0) chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        i_ready = 1'b1;
    endtask

    // Scoreboard monitor: compare on handshake, and during stalls hold against the pending word.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(o_valid), 32'd0);
            end else begin
                mon_e = q[0];
                chk(i_ready ? "word_data"  : "stall_data",  32'(o_data),  32'(mon_e.d));
                chk(i_ready ? "word_first" : "stall_first", 32'(o_first), 32'(mon_e.f));
                chk(i_ready ? "word_last"  : "stall_last",  32'(o_last),  32'(mon_e.l));
                if (i_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    localparam logic [95:0] SUM_A = 96'h99AABBCC_55667788_11223344;
    localparam logic [95:0] SUM_B = 96'hDEADBEEF_CAFEF00D_01020304;
    localparam logic [95:0] SUM_C = 96'h0F1E2D3C_4B5A6978_8796A5B4;

    initial begin
        rst_n = 1'b0; i_sum = 96'd0; i_sum_valid = 1'b0; i_ready = 1'b1;
        #12;
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_first", 32'(o_first), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame, sink always ready.
        push_frame(SUM_A);
        strobe(SUM_A);
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk("lat_first_word", 32'(o_data), 32'(q[0].d));
        wait_drain("basic", 1'b0, 1'b1, FL);
        chk("basic_idle", 32'(o_valid), 32'd0);
        chk("basic_overrun", 32'(o_overrun), 32'd0);

        // Sink toggling ready every cycle.
        @(posedge clk); #1;
        push_frame(SUM_A);
        strobe(SUM_A);
        wait_drain("toggle", 1'b1, 1'b1, 2*FL - 1);
        chk("toggle_idle", 32'(o_valid), 32'd0);

        // Overrun: second strobe at word index 5.
        @(posedge clk); #1;
        push_frame(SUM_A);
        strobe(SUM_A);
        repeat (5) begin @(posedge clk); #1; end
        strobe(SUM_B);
        wait_drain("ovr", 1'b0, 1'b1, 0);
        chk("ovr_idle", 32'(o_valid), 32'd0);
        chk("ovr_flag", 32'(o_overrun), 32'd1);
        repeat (FL + 2) begin @(posedge clk); #1; end
        chk("ovr_no_second", 32'(o_valid), 32'd0);
        chk("ovr_sticky", 32'(o_overrun), 32'd1);

        // Clear the sticky flag, then strobe exactly on the final handshake.
        rst_n = 1'b0; #1;
        chk("rst2_overrun", 32'(o_overrun), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        push_frame(SUM_A);
        strobe(SUM_A);
        repeat (FL - 1) begin @(posedge clk); #1; end
        push_frame(SUM_B);
        strobe(SUM_B);
        chk("chain_valid", 32'(o_valid), 32'd1);
        chk("chain_first", 32'(o_first), 32'd1);
        chk("chain_overrun", 32'(o_overrun), 32'd0);
        wait_drain("chain", 1'b0, 1'b1, FL);
        chk("chain_idle", 32'(o_valid), 32'd0);
        chk("chain_overrun_end", 32'(o_overrun), 32'd0);

        // Reset in the middle of a frame.
        @(posedge clk); #1;
        push_frame(SUM_A);
        strobe(SUM_A);
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        chk("midrst_data", 32'(o_data), 32'd0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_first", 32'(o_first), 32'd0);
        chk("midrst_last", 32'(o_last), 32'd0);
        q.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_resume", 32'(o_valid), 32'd0);
        push_frame(SUM_C);
        strobe(SUM_C);
        chk("midrst_new_first", 32'(o_first), 32'd1);
        wait_drain("after_rst", 1'b0, 1'b1, FL);
        chk("after_rst_idle", 32'(o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
